// File: rtl/dct16_odd_pkg.sv
// Shared definitions for the 16-point DCT odd-half MAC sequencer.
//   - Default widths for input elements, multiplier products and accumulators.
//   - FSM state type.
//   - 8x8 odd coefficient table, one 4-bit code per entry: {neg, mag[2:0]}.
//     mag indexes the product set {9, 25, 43, 57, 70, 80, 87, 90}.
package dct16_odd_pkg;

  localparam int unsigned DEF_IN_W  = 18;
  localparam int unsigned DEF_PR_W  = 25;
  localparam int unsigned DEF_ACC_W = 28;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Row r = output O[2r+1], column n = input element n.
  localparam logic [3:0] COEF [8][8] = '{
    '{4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd0 },
    '{4'd6,  4'd3,  4'd0,  4'd10, 4'd13, 4'd15, 4'd12, 4'd9 },
    '{4'd5,  4'd0,  4'd12, 4'd14, 4'd9,  4'd3,  4'd7,  4'd2 },
    '{4'd4,  4'd10, 4'd14, 4'd0,  4'd7,  4'd1,  4'd13, 4'd11},
    '{4'd3,  4'd13, 4'd9,  4'd7,  4'd8,  4'd14, 4'd2,  4'd4 },
    '{4'd2,  4'd15, 4'd3,  4'd1,  4'd14, 4'd4,  4'd0,  4'd13},
    '{4'd1,  4'd12, 4'd7,  4'd13, 4'd2,  4'd0,  4'd11, 4'd6 },
    '{4'd0,  4'd9,  4'd2,  4'd11, 4'd4,  4'd13, 4'd6,  4'd15}
  };

endpackage

// File: rtl/dct16_odd_mac_ctrl_term.sv
// Per-row coefficient term: picks one of the eight constant products, sign-extends it to the
// accumulator width and optionally negates it.
//   prods_i  8*PR_W  products, slot k = operand * {9,25,43,57,70,80,87,90}[k]
//   mag_i    3       product slot select
//   neg_i    1       negate the selected product
//   term_o   ACC_W   signed term to add into the row accumulator
module odd_coef_term
  import dct16_odd_pkg::*;
#(
  parameter int unsigned PR_W  = DEF_PR_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [8*PR_W-1:0] prods_i,
  input  logic [2:0]        mag_i,
  input  logic              neg_i,
  output logic [ACC_W-1:0]  term_o
);

  logic [PR_W-1:0]  prod;
  logic [ACC_W-1:0] ext;

  always_comb begin
    prod = '0;
    for (int k = 0; k < 8; k++) begin
      if (mag_i == 3'(k)) begin
        prod = prods_i[k*PR_W +: PR_W];
      end
    end
    ext    = {{(ACC_W-PR_W){prod[PR_W-1]}}, prod};
    term_o = neg_i ? (~ext + 1'b1) : ext;
  end

endmodule

// File: rtl/dct16_odd_mac_ctrl.sv
// Odd-half sequencer of the 16-point forward DCT partial butterfly. Captures one 8-element
// odd-difference vector, feeds the shared constant multiplier one element per cycle and
// accumulates the signed products into the eight odd outputs O[1], O[3], ..., O[15].
//   clk, rst             clock, synchronous active-high reset
//   i_valid/i_ready      input vector handshake, i_data = 8 x IN_W signed elements
//   o_valid/o_ready      result handshake, o_data = 8 x ACC_W signed rows (row r = O[2r+1])
//   o_mul_data           operand to the external constant multiplier (0 when not running)
//   i_mul_*              products of o_mul_data, combinational, same cycle
module dct16_odd_mac_ctrl
  import dct16_odd_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned PR_W  = DEF_PR_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [8*IN_W-1:0]  i_data,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [8*ACC_W-1:0] o_data,
  output logic [IN_W-1:0]    o_mul_data,
  input  logic [PR_W-1:0]    i_mul_9,
  input  logic [PR_W-1:0]    i_mul_25,
  input  logic [PR_W-1:0]    i_mul_43,
  input  logic [PR_W-1:0]    i_mul_57,
  input  logic [PR_W-1:0]    i_mul_70,
  input  logic [PR_W-1:0]    i_mul_80,
  input  logic [PR_W-1:0]    i_mul_87,
  input  logic [PR_W-1:0]    i_mul_90
);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [IN_W-1:0]   opbuf_q [8];
  logic [ACC_W-1:0]  acc_q [8];
  logic              o_valid_q;
  logic              i_ready_q;

  logic [8*PR_W-1:0] prods;
  logic [3:0]        code [8];
  logic [ACC_W-1:0]  term [8];

  // Slot order matches the magnitude index used in the coefficient table.
  assign prods = {i_mul_90, i_mul_87, i_mul_80, i_mul_70,
                  i_mul_57, i_mul_43, i_mul_25, i_mul_9};

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      code[r] = COEF[r][cnt_q];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_row
    odd_coef_term #(
      .PR_W  (PR_W),
      .ACC_W (ACC_W)
    ) u_term (
      .prods_i (prods),
      .mag_i   (code[g][2:0]),
      .neg_i   (code[g][3]),
      .term_o  (term[g])
    );
    assign o_data[g*ACC_W +: ACC_W] = acc_q[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
      for (int r = 0; r < 8; r++) begin
        acc_q[r]   <= '0;
        opbuf_q[r] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            for (int r = 0; r < 8; r++) begin
              opbuf_q[r] <= i_data[r*IN_W +: IN_W];
              acc_q[r]   <= '0;
            end
            cnt_q     <= '0;
            i_ready_q <= 1'b0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          for (int r = 0; r < 8; r++) begin
            acc_q[r] <= acc_q[r] + term[r];
          end
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            o_valid_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          // Accumulators hold, so o_data stays stable under backpressure.
          if (o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_valid    = o_valid_q;
  assign i_ready    = i_ready_q;
  assign o_mul_data = (state_q == StRun) ? opbuf_q[cnt_q] : '0;

endmodule

// File: tb/tb_dct16_odd_mac_ctrl.sv
module tb_dct16_odd_mac_ctrl;

  localparam int IN_W  = 18;
  localparam int PR_W  = 25;
  localparam int ACC_W = 28;

  // Odd DCT-16 coefficient matrix, plain integers.
  localparam int C [8][8] = '{
    '{90,  87,  80,  70,  57,  43,  25,   9},
    '{87,  57,   9, -43, -80, -90, -70, -25},
    '{80,   9, -70, -87, -25,  57,  90,  43},
    '{70, -43, -87,   9,  90,  25, -80, -57},
    '{57, -80, -25,  90,  -9, -87,  43,  70},
    '{43, -90,  57,  25, -87,  70,   9, -80},
    '{25, -70,  90, -80,  43,   9, -57,  87},
    '{ 9, -25,  43, -57,  70, -80,  87, -90}
  };

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic               i_ready;
  logic [8*IN_W-1:0]  i_data;
  logic               o_valid;
  logic               o_ready;
  logic [8*ACC_W-1:0] o_data;
  logic [IN_W-1:0]    o_mul_data;
  logic [PR_W-1:0]    i_mul_9, i_mul_25, i_mul_43, i_mul_57;
  logic [PR_W-1:0]    i_mul_70, i_mul_80, i_mul_87, i_mul_90;

  always #5 clk = ~clk;

  // Behavioural constant multiplier.
  logic signed [IN_W-1:0] m;
  assign m        = o_mul_data;
  assign i_mul_9  = PR_W'(longint'(m) * 9);
  assign i_mul_25 = PR_W'(longint'(m) * 25);
  assign i_mul_43 = PR_W'(longint'(m) * 43);
  assign i_mul_57 = PR_W'(longint'(m) * 57);
  assign i_mul_70 = PR_W'(longint'(m) * 70);
  assign i_mul_80 = PR_W'(longint'(m) * 80);
  assign i_mul_87 = PR_W'(longint'(m) * 87);
  assign i_mul_90 = PR_W'(longint'(m) * 90);

  dct16_odd_mac_ctrl #(
    .IN_W  (IN_W),
    .PR_W  (PR_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_mul_data (o_mul_data),
    .i_mul_9    (i_mul_9),
    .i_mul_25   (i_mul_25),
    .i_mul_43   (i_mul_43),
    .i_mul_57   (i_mul_57),
    .i_mul_70   (i_mul_70),
    .i_mul_80   (i_mul_80),
    .i_mul_87   (i_mul_87),
    .i_mul_90   (i_mul_90)
  );

  int     tests = 0;
  int     fails = 0;
  int     vin [8];
  longint exp_rows [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model();
    for (int r = 0; r < 8; r++) begin
      exp_rows[r] = 0;
      for (int n = 0; n < 8; n++) exp_rows[r] += longint'(C[r][n]) * longint'(vin[n]);
    end
  endfunction

  function automatic logic [8*IN_W-1:0] pack_vin();
    logic [8*IN_W-1:0] p;
    for (int n = 0; n < 8; n++) p[n*IN_W +: IN_W] = IN_W'(vin[n]);
    return p;
  endfunction

  function automatic logic signed [63:0] row(input int r);
    logic signed [ACC_W-1:0] v;
    v = o_data[r*ACC_W +: ACC_W];
    return 64'(v);
  endfunction

  // Accept vin at the coming edge; returns in the first RUN cycle.
  task automatic send();
    model();
    i_data  = pack_vin();
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  // Called in cycle T+1; follows the operand stream and checks latency and rows.
  task automatic collect(input string tag);
    int lat = 0;
    while (!o_valid && lat < 20) begin
      if (lat < 8) check({tag, ".mul"}, 64'($signed(o_mul_data)), 64'(vin[lat]));
      check({tag, ".busy_ready"}, 64'(i_ready), 64'd0);
      step();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'd8);
    check({tag, ".valid"}, 64'(o_valid), 64'd1);
    check({tag, ".ready_in_done"}, 64'(i_ready), 64'd0);
    for (int r = 0; r < 8; r++) check({tag, ".row"}, row(r), exp_rows[r]);
  endtask

  task automatic release_out(input string tag);
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    check({tag, ".idle_ready"}, 64'(i_ready), 64'd1);
    check({tag, ".idle_valid"}, 64'(o_valid), 64'd0);
    check({tag, ".idle_mul"}, 64'(o_mul_data), 64'd0);
  endtask

  initial begin
    longint hold [8];
    logic [IN_W-1:0] rv;

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset.valid", 64'(o_valid), 64'd0);
    check("reset.data", 64'(o_data != '0), 64'd0);
    check("reset.ready", 64'(i_ready), 64'd1);
    check("reset.mul", 64'(o_mul_data), 64'd0);

    // Impulse on element 0: rows are the first matrix column.
    vin = '{1, 0, 0, 0, 0, 0, 0, 0};
    send();
    collect("impulse");
    check("impulse.row0", row(0), 64'sd90);
    check("impulse.row7", row(7), 64'sd9);
    release_out("impulse");

    // All ones: rows are the row sums.
    vin = '{1, 1, 1, 1, 1, 1, 1, 1};
    send();
    collect("ones");
    check("ones.row0", row(0), 64'sd461);
    check("ones.row1", row(1), -64'sd155);
    check("ones.row7", row(7), -64'sd43);
    release_out("ones");

    // Most negative input everywhere: largest magnitudes, no wrap.
    vin = '{-131072, -131072, -131072, -131072, -131072, -131072, -131072, -131072};
    send();
    collect("extreme");
    check("extreme.row0", row(0), -64'sd60424192);
    check("extreme.row7", row(7), 64'sd5636096);
    release_out("extreme");

    // Backpressure with a second vector waiting on i_valid.
    vin = '{3, -7, 100, -2000, 5, 0, 65535, -1};
    send();
    collect("bp1");
    for (int r = 0; r < 8; r++) hold[r] = exp_rows[r];
    vin = '{-4, 11, 0, 7, -131072, 131071, 2, 9};
    i_data  = pack_vin();
    i_valid = 1'b1;
    repeat (5) begin
      step();
      check("bp.stall_valid", 64'(o_valid), 64'd1);
      check("bp.stall_ready", 64'(i_ready), 64'd0);
      for (int r = 0; r < 8; r++) check("bp.stall_row", row(r), hold[r]);
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    check("bp.idle_ready", 64'(i_ready), 64'd1);
    check("bp.idle_valid", 64'(o_valid), 64'd0);
    model();
    step();
    i_valid = 1'b0;
    check("bp.accepted", 64'(i_ready), 64'd0);
    collect("bp2");
    release_out("bp2");

    // Reset in the middle of RUN at cnt=4.
    vin = '{500, -500, 1234, -4321, 77, 88, -99, 1};
    send();
    repeat (4) step();
    check("midrst.mul_cnt4", 64'($signed(o_mul_data)), 64'(vin[4]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.ready", 64'(i_ready), 64'd1);
    check("midrst.valid", 64'(o_valid), 64'd0);
    check("midrst.data", 64'(o_data != '0), 64'd0);
    check("midrst.mul", 64'(o_mul_data), 64'd0);
    repeat (10) begin
      step();
      check("midrst.no_valid", 64'(o_valid), 64'd0);
    end
    vin = '{1, 0, 0, 0, 0, 0, 0, 0};
    send();
    collect("midrst.impulse");
    release_out("midrst.impulse");

    // Randomized vectors with random output stalls.
    for (int t = 0; t < 12; t++) begin
      for (int n = 0; n < 8; n++) begin
        rv = IN_W'($urandom);
        vin[n] = int'($signed(rv));
      end
      send();
      collect("rand");
      repeat ($urandom_range(0, 3)) begin
        step();
        for (int r = 0; r < 8; r++) check("rand.stall_row", row(r), exp_rows[r]);
      end
      release_out("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
